// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants, FSM encoding and helpers for the fetch stage and IF/ID register.
// Optional stall-cycle counter is enabled with STALL_COUNTER_EN.
package if_id_fetch_stage_pkg;

    localparam int          DATA_W           = 32;
    localparam int          RUN_CNT_W        = 8;
    localparam logic [DATA_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [DATA_W-1:0] PC_INCR          = 32'd4;
    localparam logic [DATA_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Hazard-unit / instruction-memory / ID-stage bundle for the fetch stage.
// Stall_Count exists only when STALL_COUNTER_EN is defined.
interface if_id_fetch_stage_if;
    import if_id_fetch_stage_pkg::*;

    logic              PC_Write_Enable;
    logic              IF_ID_Enable;
    logic              Flush;
    logic [DATA_W-1:0] Branch_Target;
    logic [DATA_W-1:0] Instr_In;
    logic [DATA_W-1:0] PC_Out;
    logic [DATA_W-1:0] IF_ID_PC_Plus4;
    logic [DATA_W-1:0] IF_ID_Instr;
    logic              IF_ID_Valid;
    logic              Stall_Error;
`ifdef STALL_COUNTER_EN
    logic [DATA_W-1:0] Stall_Count;
`endif

    modport master (
        output PC_Write_Enable, IF_ID_Enable, Flush, Branch_Target, Instr_In,
        input  PC_Out, IF_ID_PC_Plus4, IF_ID_Instr, IF_ID_Valid, Stall_Error
`ifdef STALL_COUNTER_EN
        , input Stall_Count
`endif
    );

    modport slave (
        input  PC_Write_Enable, IF_ID_Enable, Flush, Branch_Target, Instr_In,
        output PC_Out, IF_ID_PC_Plus4, IF_ID_Instr, IF_ID_Valid, Stall_Error
`ifdef STALL_COUNTER_EN
        , output Stall_Count
`endif
    );

endinterface

// File: rtl/if_id_fetch_stage_pc_register.sv
// Program counter flop: reset, hold, sequential increment and branch redirect.
module if_id_fetch_stage_pc_register
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              pc_write_enable,
    input  logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] pc_p0
);

    logic [DATA_W-1:0] pc_next;

    // Redirect wins over the hazard unit's hold request.
    always_comb begin
        pc_next = pc_p0;
        if (flush) begin
            pc_next = align_word(branch_target);
        end else if (pc_write_enable) begin
            pc_next = pc_p0 + PC_INCR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_next;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC, IF/ID pipeline register, stall watchdog FSM.
// Define STALL_COUNTER_EN to add the saturating Stall_Count output.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                MAX_STALL = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    if_id_fetch_stage_if.slave   fe
);

    localparam logic [RUN_CNT_W:0] MAX_STALL_W = (RUN_CNT_W+1)'(MAX_STALL);

    function automatic logic [RUN_CNT_W-1:0] sat_inc_run(input logic [RUN_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc_word(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0]    pc_p0;
    logic [DATA_W-1:0]    if_id_instr_p1;
    logic [DATA_W-1:0]    if_id_pc_plus4_p1;
    logic                 vld_p1;

    fetch_state_e         state_q, state_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [RUN_CNT_W:0]   run_cnt_would_be;
    logic                 stall_err_q, stall_err_d;
    logic                 stalled;

    assign stalled = !fe.IF_ID_Enable && !fe.Flush;

    // ---- IF: program counter ----
    if_id_fetch_stage_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk             (clk),
        .reset           (reset),
        .flush           (fe.Flush),
        .pc_write_enable (fe.PC_Write_Enable),
        .branch_target   (fe.Branch_Target),
        .pc_p0           (pc_p0)
    );

    // ---- IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (reset || fe.Flush) begin
            if_id_instr_p1    <= NOP_INSTR;
            if_id_pc_plus4_p1 <= '0;
            vld_p1            <= 1'b0;
        end else if (fe.IF_ID_Enable) begin
            if_id_instr_p1    <= fe.Instr_In;
            if_id_pc_plus4_p1 <= pc_p0 + PC_INCR;
            vld_p1            <= 1'b1;
        end
    end

    // Run counter value this edge would produce, unsaturated, for the watchdog.
    always_comb begin
        state_d          = state_q;
        run_cnt_d        = run_cnt_q;
        stall_err_d      = stall_err_q;
        run_cnt_would_be = '0;
        case (state_q)
            RUN: begin
                if (stalled) begin
                    state_d          = STALL;
                    run_cnt_d        = RUN_CNT_W'(1);
                    run_cnt_would_be = (RUN_CNT_W+1)'(1);
                end
            end
            STALL: begin
                if (stalled) begin
                    run_cnt_d        = sat_inc_run(run_cnt_q);
                    run_cnt_would_be = {1'b0, run_cnt_q} + 1'b1;
                end else begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end
            end
            default: begin
                state_d   = RUN;
                run_cnt_d = '0;
            end
        endcase
        if (stalled && (run_cnt_would_be > MAX_STALL_W)) begin
            stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            run_cnt_q   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [DATA_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stalled) begin
            stall_cnt_q <= sat_inc_word(stall_cnt_q);
        end
    end

    assign fe.Stall_Count = stall_cnt_q;
`endif

    assign fe.PC_Out         = pc_p0;
    assign fe.IF_ID_Instr    = if_id_instr_p1;
    assign fe.IF_ID_PC_Plus4 = if_id_pc_plus4_p1;
    assign fe.IF_ID_Valid    = vld_p1;
    assign fe.Stall_Error    = stall_err_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage with MAX_STALL=4; Stall_Count is
// checked only when STALL_COUNTER_EN is defined.
module tb_if_id_fetch_stage;

    logic clk;
    logic reset;

    if_id_fetch_stage_if bus();

    if_id_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MAX_STALL (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fe    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] instr;
        logic        vld;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL step%0d %s: got %h expected %h", id, nm, act, req);
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PC_Out",         e.id, bus.PC_Out,         e.pc);
            chk("IF_ID_PC_Plus4", e.id, bus.IF_ID_PC_Plus4, e.p4);
            chk("IF_ID_Instr",    e.id, bus.IF_ID_Instr,    e.instr);
            chk("IF_ID_Valid",    e.id, {31'd0, bus.IF_ID_Valid}, {31'd0, e.vld});
            chk("Stall_Error",    e.id, {31'd0, bus.Stall_Error}, {31'd0, e.err});
`ifdef STALL_COUNTER_EN
            chk("Stall_Count",    e.id, bus.Stall_Count,    e.cnt);
`endif
        end
    end

    int step_id = 0;

    task automatic step(input logic r, input logic pw, input logic ie, input logic fl,
                        input logic [31:0] tgt, input logic [31:0] ins,
                        input logic [31:0] epc, input logic [31:0] ep4, input logic [31:0] eins,
                        input logic ev, input logic eerr, input logic [31:0] ecnt);
        exp_t e;
        reset               = r;
        bus.PC_Write_Enable = pw;
        bus.IF_ID_Enable    = ie;
        bus.Flush           = fl;
        bus.Branch_Target   = tgt;
        bus.Instr_In        = ins;
        @(posedge clk);
        step_id++;
        e.id = step_id; e.pc = epc; e.p4 = ep4; e.instr = eins;
        e.vld = ev; e.err = eerr; e.cnt = ecnt;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        //    rst pw ie fl target        instr_in       PC_Out        Plus4         IF_ID_Instr   V  E  Count
        // reset held two cycles
        step(1, 1, 1, 0, 32'h0,        32'h1234_5678, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        step(1, 1, 1, 0, 32'h0,        32'h1234_5678, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        // run
        step(0, 1, 1, 0, 32'h0,        32'h2008_0005, 32'h4,        32'h4,        32'h2008_0005, 1, 0, 0);
        step(0, 1, 1, 0, 32'h0,        32'h2008_0005, 32'h8,        32'h8,        32'h2008_0005, 1, 0, 0);
        // load-use stall at PC 8
        step(0, 0, 0, 0, 32'h0,        32'hDEAD_BEEF, 32'h8,        32'h8,        32'h2008_0005, 1, 0, 1);
        step(0, 1, 1, 0, 32'h0,        32'h1111_1111, 32'hC,        32'hC,        32'h1111_1111, 1, 0, 1);
        // PC advances, fetched word discarded
        step(0, 1, 0, 0, 32'h0,        32'h2222_2222, 32'h10,       32'hC,        32'h1111_1111, 1, 0, 2);
        step(0, 1, 1, 0, 32'h0,        32'h3333_3333, 32'h14,       32'h14,       32'h3333_3333, 1, 0, 2);
        // flush overrides a simultaneous stall; low target bits dropped
        step(0, 0, 0, 1, 32'h43,       32'h4444_4444, 32'h40,       32'h0,        32'h0,        0, 0, 2);
        step(0, 1, 1, 0, 32'h0,        32'h5555_5555, 32'h44,       32'h44,       32'h5555_5555, 1, 0, 2);
        // redirect to top of memory, then wrap
        step(0, 1, 1, 1, 32'hFFFF_FFFF, 32'h6666_6666, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 0, 2);
        step(0, 1, 1, 0, 32'h0,        32'h7777_7777, 32'h0,        32'h0,        32'h7777_7777, 1, 0, 2);
        step(0, 1, 1, 0, 32'h0,        32'h8888_8888, 32'h4,        32'h4,        32'h8888_8888, 1, 0, 2);
        // three stalls, flush with IF_ID_Enable low, run
        step(0, 0, 0, 0, 32'h0,        32'h9999_9999, 32'h4,        32'h4,        32'h8888_8888, 1, 0, 3);
        step(0, 0, 0, 0, 32'h0,        32'h9999_9999, 32'h4,        32'h4,        32'h8888_8888, 1, 0, 4);
        step(0, 0, 0, 0, 32'h0,        32'h9999_9999, 32'h4,        32'h4,        32'h8888_8888, 1, 0, 5);
        step(0, 0, 0, 1, 32'h100,      32'h9999_9999, 32'h100,      32'h0,        32'h0,        0, 0, 5);
        step(0, 1, 1, 0, 32'h0,        32'hAAAA_AAAA, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 0, 5);
        // five stalls against MAX_STALL=4: error on the fifth edge
        step(0, 0, 0, 0, 32'h0,        32'h0BAD_0BAD, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 0, 6);
        step(0, 0, 0, 0, 32'h0,        32'h0BAD_0BAD, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 0, 7);
        step(0, 0, 0, 0, 32'h0,        32'h0BAD_0BAD, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 0, 8);
        step(0, 0, 0, 0, 32'h0,        32'h0BAD_0BAD, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 0, 9);
        step(0, 0, 0, 0, 32'h0,        32'h0BAD_0BAD, 32'h104,      32'h104,      32'hAAAA_AAAA, 1, 1, 10);
        // error is sticky through run and flush
        step(0, 1, 1, 0, 32'h0,        32'hBBBB_BBBB, 32'h108,      32'h108,      32'hBBBB_BBBB, 1, 1, 10);
        step(0, 1, 1, 1, 32'h20,       32'hBBBB_BBBB, 32'h20,       32'h0,        32'h0,        0, 1, 10);
        step(0, 0, 0, 0, 32'h0,        32'hBBBB_BBBB, 32'h20,       32'h0,        32'h0,        0, 1, 11);
        // reset mid-stall with flush asserted: reset wins
        step(1, 0, 0, 1, 32'h80,       32'hBBBB_BBBB, 32'h0,        32'h0,        32'h0,        0, 0, 0);
        step(0, 1, 1, 0, 32'h0,        32'hCCCC_CCCC, 32'h4,        32'h4,        32'hCCCC_CCCC, 1, 0, 0);
        // exactly MAX_STALL stalls does not trip the watchdog
        step(0, 0, 0, 0, 32'h0,        32'h0,         32'h4,        32'h4,        32'hCCCC_CCCC, 1, 0, 1);
        step(0, 0, 0, 0, 32'h0,        32'h0,         32'h4,        32'h4,        32'hCCCC_CCCC, 1, 0, 2);
        step(0, 0, 0, 0, 32'h0,        32'h0,         32'h4,        32'h4,        32'hCCCC_CCCC, 1, 0, 3);
        step(0, 0, 0, 0, 32'h0,        32'h0,         32'h4,        32'h4,        32'hCCCC_CCCC, 1, 0, 4);
        step(0, 1, 1, 0, 32'h0,        32'hDDDD_DDDD, 32'h8,        32'h8,        32'hDDDD_DDDD, 1, 0, 4);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", step_id, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

Front end of the 5-stage pipeline: owns the program counter and the IF/ID pipeline register, and is the consumer of the load-use stall controls and branch redirects. It holds, advances or flushes the fetch path each cycle. It tracks consecutive stall cycles and flags a stuck pipeline. It sits between instruction memory and the ID stage register file/decoder.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_STALL, 16, consecutive stall cycles (IF_ID_Enable low) tolerated before Stall_Error sets; range 1..255
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  reset is synchronous and active-high
- PC_Write_Enable  input  1  1 = PC may update; 0 = hold PC (from hazard unit)
- IF_ID_Enable  input  1  1 = IF/ID register loads; 0 = hold (from hazard unit)
- Flush  input  1  taken branch/jump resolved; redirect and squash
- Branch_Target  input  32  redirect address; bits [1:0] forced to 00
- Instr_In  input  32  instruction memory read data for PC_Out (combinational read)
- PC_Out  output  32  current fetch address to instruction memory
- IF_ID_PC_Plus4  output  32  PC+4 of the instruction held in IF/ID
- IF_ID_Instr  output  32  instruction held in IF/ID
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
- Stall_Error  output  1  sticky; stall exceeded MAX_STALL
- Stall_Count  output  32  cycles spent stalled (only with STALL_COUNTER_EN)

## Operation
- Per-edge priority: reset > Flush > enables.
- Reset: PC_Out=RESET_PC, IF_ID_PC_Plus4=0, IF_ID_Instr=32'h0000_0000 (NOP), IF_ID_Valid=0, Stall_Error=0, Stall_Count=0, FSM=RUN, run counter=0.
- Flush=1: PC_Out<={Branch_Target[31:2],2'b00}; IF_ID_Instr<=NOP, IF_ID_Valid<=0, IF_ID_PC_Plus4<=0. This overrides both enables, including a simultaneous load-use stall.
- No flush: if PC_Write_Enable, PC_Out<=PC_Out+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); else PC_Out holds.
- No flush: if IF_ID_Enable, IF_ID_Instr<=Instr_In, IF_ID_PC_Plus4<=PC_Out+4, IF_ID_Valid<=1; else all three hold.
- Enables are independent. PC_Write_Enable=1 with IF_ID_Enable=0 advances the PC and discards the fetched word; this is legal and is not an error.
- FSM states:
  - RUN: IF_ID_Enable=1 or Flush. On IF_ID_Enable=0 with no Flush, go to STALL and set run counter=1.
  - STALL: run counter increments per stalled cycle and saturates at 255. Return to RUN on IF_ID_Enable=1 or Flush, clearing the counter.
- Stall_Error sets on the edge where the run counter would exceed MAX_STALL. Only reset clears it.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Fetch latency: the word at PC_Out in cycle n appears on IF_ID_Instr in cycle n+1.
- Stall: enables low in cycle n means PC_Out and IF/ID are unchanged in cycle n+1.
- Flush in cycle n: PC_Out=target and IF_ID_Valid=0 in cycle n+1; the target instruction reaches IF/ID in cycle n+2.
- Reset asserted mid-stall or mid-flush takes effect at the next edge and overrides everything.

## Configuration
- STALL_COUNTER_EN defined: the Stall_Count port exists. It increments on every non-reset edge with IF_ID_Enable=0 and Flush=0, and saturates at 32'hFFFF_FFFF.
- STALL_COUNTER_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000
  - PC_INCR = 4
  - FSM state encoding: RUN=1'b0, STALL=1'b1
  - default RESET_PC
- Sub-module pc_register: the PC flop with reset, hold, increment and redirect mux.
- IF/ID register, FSM and counters live in the top module.

## Test plan
- Reset then run: hold reset 2 cycles, release, Instr_In=32'h2008_0005 -> PC_Out 0,4,8; the next cycle gives IF_ID_Instr=32'h2008_0005, IF_ID_PC_Plus4=4, IF_ID_Valid=1.
- Load-use stall: both enables 0 for 1 cycle at PC_Out=8 -> PC_Out stays 8 and IF/ID unchanged for one cycle, then resumes to 12.
- Flush vs. stall: Flush=1, Branch_Target=32'h0000_0043, both enables 0 -> next cycle PC_Out=32'h40, IF_ID_Valid=0, IF_ID_Instr=0.
- Wrap: redirect to 32'hFFFF_FFFC, then run -> PC_Out=0 next cycle and IF_ID_PC_Plus4=0.
- Watchdog: MAX_STALL=4, IF_ID_Enable=0 for 5 cycles -> Stall_Error=1 after the 5th edge; it stays 1 after the stall ends, until reset.
- Counter (STALL_COUNTER_EN): 3 stalled cycles, 1 flush cycle with IF_ID_Enable=0, then run -> Stall_Count=3; a reset mid-stall returns it to 0.
